// File: rtl/vend_controller_if.sv
// Signal bundle between the vending controller and its coin/select front end and display manager.
interface vend_controller_if;
  logic       nickel;
  logic       dime;
  logic       quarter;
  logic       sel_a;
  logic       sel_b;
  logic       sel_c;
  logic       sel_d;
  logic       cancel;
  logic       apple;
  logic       banana;
  logic       carrot;
  logic       date;
  logic       error;
  logic [7:0] credit;
  logic       coin_return;
  logic       refund_valid;
  logic [7:0] refund;

  modport master (
    output nickel, dime, quarter, sel_a, sel_b, sel_c, sel_d, cancel,
    input  apple, banana, carrot, date, error, credit, coin_return, refund_valid, refund
  );

  modport slave (
    input  nickel, dime, quarter, sel_a, sel_b, sel_c, sel_d, cancel,
    output apple, banana, carrot, date, error, credit, coin_return, refund_valid, refund
  );
endinterface

// File: rtl/vend_controller.sv
// Vending sequencer: credit accounting, vend/error decisions and post-event lockout.
// Optional feature macro VEND_AUTO_REFUND_EN refunds leftover credit the cycle after a vend.
module vend_controller #(
  parameter int PRICE_A     = 25,
  parameter int PRICE_B     = 40,
  parameter int PRICE_C     = 55,
  parameter int PRICE_D     = 75,
  parameter int HOLD_CYCLES = 6
) (
  input logic              clk,
  input logic              reset,
  vend_controller_if.slave bus
);
  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [6:0] P_A        = 7'(PRICE_A);
  localparam logic [6:0] P_B        = 7'(PRICE_B);
  localparam logic [6:0] P_C        = 7'(PRICE_C);
  localparam logic [6:0] P_D        = 7'(PRICE_D);
  localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYCLES - 1);
  localparam logic [7:0] MAX_CREDIT = 8'd95;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] credit_q, credit_d;
  logic [7:0] credit_bcd_q;
  logic [7:0] refund_q, refund_d;
  logic [3:0] fruit_q, fruit_d;
  logic       error_q, error_d;
  logic       coin_ret_q, coin_ret_d;
  logic       refund_v_q, refund_v_d;
`ifdef VEND_AUTO_REFUND_EN
  logic       pend_q, pend_d;
`endif

  logic [2:0] coins;
  logic [3:0] sels;
  logic       multi_coin, multi_sel;
  logic [6:0] coin_val;
  logic [7:0] coin_sum;
  logic [6:0] price;

  assign coins      = {bus.nickel, bus.dime, bus.quarter};
  assign sels       = {bus.sel_a, bus.sel_b, bus.sel_c, bus.sel_d};
  assign multi_coin = (coins & (coins - 3'd1)) != '0;
  assign multi_sel  = (sels & (sels - 4'd1)) != '0;
  assign coin_val   = bus.quarter ? 7'd25 : (bus.dime ? 7'd10 : 7'd5);
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
  assign price      = bus.sel_a ? P_A : (bus.sel_b ? P_B : (bus.sel_c ? P_C : P_D));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    credit_d   = credit_q;
    refund_d   = refund_q;
    fruit_d    = '0;
    error_d    = 1'b0;
    coin_ret_d = 1'b0;
    refund_v_d = 1'b0;
`ifdef VEND_AUTO_REFUND_EN
    pend_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Coins outrank cancel, cancel outranks selects.
        if (coins != '0) begin
          if (multi_coin || coin_sum > MAX_CREDIT) coin_ret_d = 1'b1;
          else                                     credit_d   = coin_sum[6:0];
        end else if (bus.cancel) begin
          if (credit_q != '0) begin
            refund_v_d = 1'b1;
            refund_d   = to_bcd(credit_q);
            credit_d   = '0;
          end
        end else if (sels != '0) begin
          state_d = LOCK;
          cnt_d   = HOLD_LOAD;
          if (multi_sel || credit_q < price) begin
            error_d = 1'b1;
          end else begin
            credit_d = credit_q - price;
            fruit_d  = sels;
`ifdef VEND_AUTO_REFUND_EN
            pend_d   = 1'b1;
`endif
          end
        end
      end
      LOCK: begin
        coin_ret_d = coins != '0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 4'd1;
`ifdef VEND_AUTO_REFUND_EN
        if (pend_q && credit_q != '0) begin
          refund_v_d = 1'b1;
          refund_d   = to_bcd(credit_q);
          credit_d   = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      credit_q     <= '0;
      credit_bcd_q <= '0;
      refund_q     <= '0;
      fruit_q      <= '0;
      error_q      <= 1'b0;
      coin_ret_q   <= 1'b0;
      refund_v_q   <= 1'b0;
`ifdef VEND_AUTO_REFUND_EN
      pend_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      credit_q     <= credit_d;
      credit_bcd_q <= to_bcd(credit_d);
      refund_q     <= refund_d;
      fruit_q      <= fruit_d;
      error_q      <= error_d;
      coin_ret_q   <= coin_ret_d;
      refund_v_q   <= refund_v_d;
`ifdef VEND_AUTO_REFUND_EN
      pend_q       <= pend_d;
`endif
    end
  end

  assign bus.apple        = fruit_q[3];
  assign bus.banana       = fruit_q[2];
  assign bus.carrot       = fruit_q[1];
  assign bus.date         = fruit_q[0];
  assign bus.error        = error_q;
  assign bus.credit       = credit_bcd_q;
  assign bus.coin_return  = coin_ret_q;
  assign bus.refund_valid = refund_v_q;
  assign bus.refund       = refund_q;
endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: vector table through a scoreboard, plus a held-select lockout sequence.
module tb_vend_controller;
`ifdef VEND_AUTO_REFUND_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam logic [2:0] CN = 3'b000, NK = 3'b100, DM = 3'b010, QT = 3'b001;
  localparam logic [3:0] SN = 4'b0000, SA = 4'b1000, SB = 4'b0100, SC = 4'b0010, SD = 4'b0001;
  localparam logic [4:0] EN = 5'b00000, EA = 5'b10000, EDT = 5'b00010, EE = 5'b00001;

  typedef struct {
    string       name;
    bit          rst;
    logic [2:0]  coin;
    logic [3:0]  sel;
    bit          can;
    logic [22:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [22:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  vend_controller_if bus ();

  vend_controller #(
    .PRICE_A(25), .PRICE_B(40), .PRICE_C(55), .PRICE_D(75), .HOLD_CYCLES(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [22:0] observed();
    return {bus.apple, bus.banana, bus.carrot, bus.date, bus.error,
            bus.credit, bus.coin_return, bus.refund_valid, bus.refund};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input bit rst, input logic [2:0] c, input logic [3:0] s, input bit cn);
    reset       = rst;
    bus.nickel  = c[2];
    bus.dime    = c[1];
    bus.quarter = c[0];
    bus.sel_a   = s[3];
    bus.sel_b   = s[2];
    bus.sel_c   = s[1];
    bus.sel_d   = s[0];
    bus.cancel  = cn;
  endtask

  task automatic add(input string nm, input bit rst, input logic [2:0] c, input logic [3:0] s,
                     input bit cn, input logic [4:0] ev, input logic [7:0] cr, input bit ret,
                     input bit rv, input logic [7:0] rf);
    vec_t v;
    v.name = nm; v.rst = rst; v.coin = c; v.sel = s; v.can = cn;
    v.exp  = {ev, cr, ret, rv, rf};
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    sb_t e;
    @(negedge clk);
    drive(v.rst, v.coin, v.sel, v.can);
    e.name = v.name;
    e.exp  = v.exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h expected entry", v.name, observed());
    end else begin
      e = sb.pop_front();
      check(e.name, {9'd0, observed()}, {9'd0, e.exp});
    end
  endtask

  initial begin
    logic [7:0] c15, rf_a;
    logic [4:0] exp_ev;
    logic [7:0] exp_cr;

    drive(1'b1, CN, SN, 1'b0);
    c15  = AUTO ? 8'h00 : 8'h15;
    rf_a = AUTO ? 8'h15 : 8'h00;

    // Reset, coins, vend and lockout boundary
    add("reset",        1, CN, SN, 0, EN, 8'h00, 0, 0, 8'h00);
    add("quarter",      0, QT, SN, 0, EN, 8'h25, 0, 0, 8'h00);
    add("dime",         0, DM, SN, 0, EN, 8'h35, 0, 0, 8'h00);
    add("nickel",       0, NK, SN, 0, EN, 8'h40, 0, 0, 8'h00);
    add("vend_a",       0, CN, SA, 0, EA, 8'h15, 0, 0, 8'h00);
    add("lock_sel_b",   0, CN, SB, 0, EN, c15,   0, AUTO, rf_a);
    for (int i = 0; i < 4; i++) add("lock_idle", 0, CN, SN, 0, EN, c15, 0, 0, rf_a);
    add("lock_last_coin", 0, QT, SN, 0, EN, c15, 1, 0, rf_a);
    add("sel_b_low",    0, CN, SB, 0, EE, c15,   0, 0, rf_a);
    for (int i = 0; i < 6; i++) add("lock2_idle", 0, CN, SN, 0, EN, c15, 0, 0, rf_a);
    // Overflow, double coin, exact-95 boundary, cancel
    add("reset2",       1, CN, SN, 0, EN, 8'h00, 0, 0, 8'h00);
    add("q_25",         0, QT, SN, 0, EN, 8'h25, 0, 0, 8'h00);
    add("q_50",         0, QT, SN, 0, EN, 8'h50, 0, 0, 8'h00);
    add("q_75",         0, QT, SN, 0, EN, 8'h75, 0, 0, 8'h00);
    add("n_80",         0, NK, SN, 0, EN, 8'h80, 0, 0, 8'h00);
    add("ovf_quarter",  0, QT, SN, 0, EN, 8'h80, 1, 0, 8'h00);
    add("double_coin",  0, NK | DM, SN, 0, EN, 8'h80, 1, 0, 8'h00);
    add("d_90",         0, DM, SN, 0, EN, 8'h90, 0, 0, 8'h00);
    add("n_95",         0, NK, SN, 0, EN, 8'h95, 0, 0, 8'h00);
    add("ovf_nickel",   0, NK, SN, 0, EN, 8'h95, 1, 0, 8'h00);
    add("cancel_95",    0, CN, SN, 1, EN, 8'h00, 0, 1, 8'h95);
    add("cancel_zero",  0, CN, SN, 1, EN, 8'h00, 0, 0, 8'h95);
    add("q_25b",        0, QT, SN, 0, EN, 8'h25, 0, 0, 8'h95);
    add("q_50b",        0, QT, SN, 0, EN, 8'h50, 0, 0, 8'h95);
    add("n_55",         0, NK, SN, 0, EN, 8'h55, 0, 0, 8'h95);
    add("cancel_55",    0, CN, SN, 1, EN, 8'h00, 0, 1, 8'h55);
    add("cancel_again", 0, CN, SN, 1, EN, 8'h00, 0, 0, 8'h55);
    // Simultaneous inputs
    add("q_25c",        0, QT, SN, 0, EN, 8'h25, 0, 0, 8'h55);
    add("sel_a_c",      0, CN, SA | SC, 0, EE, 8'h25, 0, 0, 8'h55);
    for (int i = 0; i < 6; i++) add("lock3_idle", 0, CN, SN, 0, EN, 8'h25, 0, 0, 8'h55);
    add("dime_sel_a",   0, DM, SA, 0, EN, 8'h35, 0, 0, 8'h55);
    add("cancel_sel_a", 0, CN, SA, 1, EN, 8'h00, 0, 1, 8'h35);
    add("sel_d_zero",   0, CN, SD, 0, EE, 8'h00, 0, 0, 8'h35);
    for (int i = 0; i < 6; i++) add("lock4_idle", 0, CN, SN, 0, EN, 8'h00, 0, 0, 8'h35);
    // Vend with remainder, then reset inside the lockout
    add("q_25d",        0, QT, SN, 0, EN, 8'h25, 0, 0, 8'h35);
    add("q_50d",        0, QT, SN, 0, EN, 8'h50, 0, 0, 8'h35);
    add("q_75d",        0, QT, SN, 0, EN, 8'h75, 0, 0, 8'h35);
    add("d_85",         0, DM, SN, 0, EN, 8'h85, 0, 0, 8'h35);
    add("d_95",         0, DM, SN, 0, EN, 8'h95, 0, 0, 8'h35);
    add("vend_d",       0, CN, SD, 0, EDT, 8'h20, 0, 0, 8'h35);
    add("after_vend_d", 0, CN, SN, 0, EN, AUTO ? 8'h00 : 8'h20, 0, AUTO, AUTO ? 8'h20 : 8'h35);
    add("reset_in_lock", 1, CN, SN, 0, EN, 8'h00, 0, 0, 8'h00);
    add("post_reset_q", 0, QT, SN, 0, EN, 8'h25, 0, 0, 8'h00);
    add("q_to_50",      0, QT, SN, 0, EN, 8'h50, 0, 0, 8'h00);

    foreach (vecs[k]) apply(vecs[k]);

    // sel_a held high across two lockout windows: accepted at offsets 0, 7 and 14 only
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b0, CN, SA, 1'b0);
      @(posedge clk);
      #1;
      if (i == 0)       exp_ev = EA;
      else if (i == 7)  exp_ev = AUTO ? EE : EA;
      else if (i == 14) exp_ev = EE;
      else              exp_ev = EN;
      exp_cr = (i == 0) ? 8'h25 : ((AUTO || i >= 7) ? 8'h00 : 8'h25);
      check($sformatf("held_sel_a[%0d]", i),
            {19'd0, bus.apple, bus.banana, bus.carrot, bus.date, bus.error, bus.credit},
            {19'd0, exp_ev, exp_cr});
    end

    @(negedge clk);
    drive(1'b0, CN, SN, 1'b0);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
